// File: rtl/cache_line_fill_ctrl_if.sv
// Fill/store request, memory burst and cache-line RAM write signals of
// cache_line_fill_ctrl. The controller uses the slave modport and its driver uses master.
interface cache_line_fill_ctrl_if;
  logic         iFILL_REQ;
  logic [31:0]  iFILL_ADDR;
  logic         oFILL_BUSY;
  logic         oFILL_DONE;
  logic         oMEM_REQ;
  logic [31:0]  oMEM_ADDR;
  logic         iMEM_ACK;
  logic         iMEM_VALID;
  logic [31:0]  iMEM_DATA;
  logic         iSTORE_REQ;
  logic [3:0]   iSTORE_ENTRY;
  logic [2:0]   iSTORE_WORD;
  logic [3:0]   iSTORE_MASK;
  logic [31:0]  iSTORE_DATA;
  logic         oSTORE_ACK;
  logic         oRAM_WREN;
  logic [3:0]   oRAM_WRADDRESS;
  logic [31:0]  oRAM_BYTEENA;
  logic [255:0] oRAM_DATA;

  modport slave (
    input  iFILL_REQ, iFILL_ADDR, iMEM_ACK, iMEM_VALID, iMEM_DATA,
           iSTORE_REQ, iSTORE_ENTRY, iSTORE_WORD, iSTORE_MASK, iSTORE_DATA,
    output oFILL_BUSY, oFILL_DONE, oMEM_REQ, oMEM_ADDR, oSTORE_ACK,
           oRAM_WREN, oRAM_WRADDRESS, oRAM_BYTEENA, oRAM_DATA
  );

  modport master (
    output iFILL_REQ, iFILL_ADDR, iMEM_ACK, iMEM_VALID, iMEM_DATA,
           iSTORE_REQ, iSTORE_ENTRY, iSTORE_WORD, iSTORE_MASK, iSTORE_DATA,
    input  oFILL_BUSY, oFILL_DONE, oMEM_REQ, oMEM_ADDR, oSTORE_ACK,
           oRAM_WREN, oRAM_WRADDRESS, oRAM_BYTEENA, oRAM_DATA
  );
endinterface

// File: rtl/cache_line_fill_ctrl.sv
// Cache line RAM write front end: 8x32 burst line fill plus byte-masked store hits.
// Define CACHE_FILL_CRITICAL_FIRST_EN for critical-word-first wrapping bursts.
//
// state | meaning
// IDLE  | accept store hits (priority) or capture a fill request
// REQ   | burst request held on the memory port until acked
// FILL  | collect 8 read beats into the line buffer
// WRITE | full-line RAM write driven
// DONE  | fill-done pulse, line now readable
module cache_line_fill_ctrl #(
  parameter int LINE_BEATS = 8,
  parameter int INDEX_LSB  = 5
) (
  input logic             iCLOCK,
  input logic             inRESET,
  cache_line_fill_ctrl_if.slave bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] REQ   = 3'd1;
  localparam logic [2:0] FILL  = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]   state;
  logic [2:0]   beat;
  logic [255:0] line;
  logic [255:0] line_next;
  logic [31:0]  fill_addr;
  logic [2:0]   slot;
  logic [3:0]   fill_entry;
  logic         last_beat;

  assign fill_entry = fill_addr[INDEX_LSB+3:INDEX_LSB];
  assign last_beat  = (beat == 3'(LINE_BEATS - 1));

`ifdef CACHE_FILL_CRITICAL_FIRST_EN
  wire unused_addr_bits = ^fill_addr[1:0];
  // Wrapping burst: beat k lands in slot (critical word + k) mod 8.
  assign slot          = fill_addr[4:2] + beat;
  assign bus.oMEM_ADDR = (state == REQ) ? {fill_addr[31:2], 2'b00} : 32'h0;
`else
  wire unused_addr_bits = ^fill_addr[4:0];
  assign slot          = beat;
  assign bus.oMEM_ADDR = (state == REQ) ? {fill_addr[31:5], 5'b0} : 32'h0;
`endif

  always_comb begin
    line_next = line;
    line_next[{slot, 5'b00000} +: 32] = bus.iMEM_DATA;
  end

  assign bus.oFILL_BUSY = (state != IDLE);
  assign bus.oFILL_DONE = (state == DONE);
  assign bus.oMEM_REQ   = (state == REQ);
  assign bus.oSTORE_ACK = (state == IDLE) && bus.iSTORE_REQ;

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state              <= IDLE;
      beat               <= 3'd0;
      line               <= '0;
      fill_addr          <= 32'h0;
      bus.oRAM_WREN      <= 1'b0;
      bus.oRAM_WRADDRESS <= 4'h0;
      bus.oRAM_BYTEENA   <= 32'h0;
      bus.oRAM_DATA      <= '0;
    end else begin
      bus.oRAM_WREN <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.iSTORE_REQ) begin
            bus.oRAM_WREN      <= 1'b1;
            bus.oRAM_WRADDRESS <= bus.iSTORE_ENTRY;
            bus.oRAM_BYTEENA   <= 32'(bus.iSTORE_MASK) << {bus.iSTORE_WORD, 2'b00};
            bus.oRAM_DATA      <= {8{bus.iSTORE_DATA}};
          end else if (bus.iFILL_REQ) begin
            fill_addr <= bus.iFILL_ADDR;
            state     <= REQ;
          end
        end
        REQ: begin
          if (bus.iMEM_ACK) begin
            beat  <= 3'd0;
            state <= FILL;
          end
        end
        FILL: begin
          if (bus.iMEM_VALID) begin
            line <= line_next;
            beat <= beat + 3'd1;
            if (last_beat) begin
              // RAM port is registered, so load it now to be live during WRITE.
              bus.oRAM_WREN      <= 1'b1;
              bus.oRAM_WRADDRESS <= fill_entry;
              bus.oRAM_BYTEENA   <= 32'hFFFF_FFFF;
              bus.oRAM_DATA      <= line_next;
              state              <= WRITE;
            end
          end
        end
        WRITE:   state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_line_fill_ctrl.sv
// Directed bench for cache_line_fill_ctrl: reset, aligned fill, stores, arbitration,
// reset during a burst, and burst word ordering.
module tb_cache_line_fill_ctrl;
  logic iCLOCK = 1'b0;
  logic inRESET = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   wr_cnt = 0;

  cache_line_fill_ctrl_if bus();

  cache_line_fill_ctrl dut (
    .iCLOCK  (iCLOCK),
    .inRESET (inRESET),
    .bus     (bus)
  );

  always #5 iCLOCK = ~iCLOCK;

  always @(negedge iCLOCK) if (bus.oRAM_WREN === 1'b1) wr_cnt++;

  initial begin
    #500us;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic send_beats(input logic [7:0][31:0] d, input int gap_after, input int gap_len);
    for (int k = 0; k < 8; k++) begin
      bus.iMEM_VALID = 1'b1;
      bus.iMEM_DATA  = d[k];
      tick();
      bus.iMEM_VALID = 1'b0;
      if (k == gap_after) repeat (gap_len) tick();
    end
  endtask

  task automatic test_reset();
    bus.iFILL_REQ = 0; bus.iFILL_ADDR = 0; bus.iMEM_ACK = 0; bus.iMEM_VALID = 0;
    bus.iMEM_DATA = 0; bus.iSTORE_REQ = 0; bus.iSTORE_ENTRY = 0; bus.iSTORE_WORD = 0;
    bus.iSTORE_MASK = 0; bus.iSTORE_DATA = 0;
    inRESET = 1'b0;
    repeat (3) tick();
    inRESET = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_vec++;
      if ({bus.oFILL_BUSY, bus.oFILL_DONE, bus.oMEM_REQ, bus.oSTORE_ACK, bus.oRAM_WREN} !== 5'b0 ||
          bus.oMEM_ADDR !== 32'h0 || bus.oRAM_WRADDRESS !== 4'h0 || bus.oRAM_BYTEENA !== 32'h0 ||
          bus.oRAM_DATA !== 256'h0) begin
        n_err++;
        $display("FAIL reset_idle cycle %0d: busy=%0b done=%0b mreq=%0b ack=%0b wren=%0b maddr=%h be=%h want all 0",
                 i, bus.oFILL_BUSY, bus.oFILL_DONE, bus.oMEM_REQ, bus.oSTORE_ACK, bus.oRAM_WREN,
                 bus.oMEM_ADDR, bus.oRAM_BYTEENA);
      end
    end
  endtask

  task automatic test_fill();
    logic [7:0][31:0] d;
    logic [255:0] exp;
    for (int k = 0; k < 8; k++) d[k] = 32'(k);
    exp = {32'h7, 32'h6, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1, 32'h0};
    bus.iFILL_ADDR = 32'h0000_1260;
    bus.iFILL_REQ  = 1'b1;
    tick();
    n_vec++;
    if (bus.oMEM_REQ !== 1'b1 || bus.oMEM_ADDR !== 32'h0000_1260) begin
      n_err++;
      $display("FAIL fill_memreq got req=%0b addr=%h want 1 00001260", bus.oMEM_REQ, bus.oMEM_ADDR);
    end
    tick(); tick();
    bus.iMEM_ACK = 1'b1;
    tick();
    bus.iMEM_ACK = 1'b0;
    n_vec++;
    if (bus.oMEM_REQ !== 1'b0 || bus.oFILL_BUSY !== 1'b1) begin
      n_err++;
      $display("FAIL fill_acked got req=%0b busy=%0b want 0 1", bus.oMEM_REQ, bus.oFILL_BUSY);
    end
    send_beats(d, 3, 2);
    n_vec++;
    if (bus.oRAM_WREN !== 1'b1 || bus.oRAM_WRADDRESS !== 4'd3 || bus.oRAM_BYTEENA !== 32'hFFFF_FFFF ||
        bus.oRAM_DATA !== exp || wr_cnt != 0) begin
      n_err++;
      $display("FAIL fill_write got wren=%0b entry=%0d be=%h prior_writes=%0d data=%h want 1 3 ffffffff 0 %h",
               bus.oRAM_WREN, bus.oRAM_WRADDRESS, bus.oRAM_BYTEENA, wr_cnt, bus.oRAM_DATA, exp);
    end
    tick();
    bus.iFILL_REQ = 1'b0;
    n_vec++;
    if (bus.oFILL_DONE !== 1'b1 || bus.oRAM_WREN !== 1'b0) begin
      n_err++;
      $display("FAIL fill_done got done=%0b wren=%0b want 1 0", bus.oFILL_DONE, bus.oRAM_WREN);
    end
    tick();
    n_vec++;
    if (bus.oFILL_DONE !== 1'b0 || bus.oFILL_BUSY !== 1'b0 || wr_cnt != 1) begin
      n_err++;
      $display("FAIL fill_idle got done=%0b busy=%0b writes=%0d want 0 0 1", bus.oFILL_DONE, bus.oFILL_BUSY, wr_cnt);
    end
  endtask

  task automatic test_store();
    bus.iSTORE_REQ = 1'b1; bus.iSTORE_ENTRY = 4'd5; bus.iSTORE_WORD = 3'd6;
    bus.iSTORE_MASK = 4'b0110; bus.iSTORE_DATA = 32'hAABB_CCDD;
    #1;
    n_vec++;
    if (bus.oSTORE_ACK !== 1'b1) begin
      n_err++;
      $display("FAIL store_ack got %0b want 1", bus.oSTORE_ACK);
    end
    tick();
    bus.iSTORE_REQ = 1'b0;
    n_vec++;
    if (bus.oRAM_WREN !== 1'b1 || bus.oRAM_WRADDRESS !== 4'd5 || bus.oRAM_BYTEENA !== 32'h0600_0000 ||
        bus.oRAM_DATA !== {8{32'hAABB_CCDD}}) begin
      n_err++;
      $display("FAIL store_write got wren=%0b entry=%0d be=%h data=%h want 1 5 06000000 aabbccdd x8",
               bus.oRAM_WREN, bus.oRAM_WRADDRESS, bus.oRAM_BYTEENA, bus.oRAM_DATA);
    end
    bus.iSTORE_REQ = 1'b1; bus.iSTORE_ENTRY = 4'd11; bus.iSTORE_WORD = 3'd2;
    bus.iSTORE_MASK = 4'b0000; bus.iSTORE_DATA = 32'h0102_0304;
    tick();
    bus.iSTORE_REQ = 1'b0;
    n_vec++;
    if (bus.oRAM_WREN !== 1'b1 || bus.oRAM_WRADDRESS !== 4'd11 || bus.oRAM_BYTEENA !== 32'h0) begin
      n_err++;
      $display("FAIL store_mask0 got wren=%0b entry=%0d be=%h want 1 11 00000000",
               bus.oRAM_WREN, bus.oRAM_WRADDRESS, bus.oRAM_BYTEENA);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0][31:0] d;
    for (int k = 0; k < 8; k++) d[k] = 32'hF000_0000 | 32'(k);
    bus.iFILL_ADDR = 32'h0000_0080; bus.iFILL_REQ = 1'b1;
    bus.iSTORE_REQ = 1'b1; bus.iSTORE_ENTRY = 4'd1; bus.iSTORE_WORD = 3'd0;
    bus.iSTORE_MASK = 4'b0001; bus.iSTORE_DATA = 32'h0000_00AA;
    #1;
    n_vec++;
    if (bus.oSTORE_ACK !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_ack_first got %0b want 1", bus.oSTORE_ACK);
    end
    tick();
    bus.iSTORE_ENTRY = 4'd9; bus.iSTORE_WORD = 3'd7; bus.iSTORE_MASK = 4'b1000;
    bus.iSTORE_DATA = 32'h1234_5678;
    #1;
    n_vec++;
    if (bus.oRAM_WREN !== 1'b1 || bus.oRAM_BYTEENA !== 32'h0000_0001 || bus.oSTORE_ACK !== 1'b1 ||
        bus.oMEM_REQ !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_store_a got wren=%0b be=%h ack=%0b mreq=%0b want 1 00000001 1 0",
               bus.oRAM_WREN, bus.oRAM_BYTEENA, bus.oSTORE_ACK, bus.oMEM_REQ);
    end
    tick();
    bus.iSTORE_REQ = 1'b0;
    n_vec++;
    if (bus.oRAM_WREN !== 1'b1 || bus.oRAM_WRADDRESS !== 4'd9 || bus.oRAM_BYTEENA !== 32'h8000_0000 ||
        bus.oRAM_DATA !== {8{32'h1234_5678}} || bus.oMEM_REQ !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_store_b got wren=%0b entry=%0d be=%h mreq=%0b want 1 9 80000000 0",
               bus.oRAM_WREN, bus.oRAM_WRADDRESS, bus.oRAM_BYTEENA, bus.oMEM_REQ);
    end
    tick();
    n_vec++;
    if (bus.oMEM_REQ !== 1'b1 || bus.oMEM_ADDR !== 32'h0000_0080 || bus.oRAM_WREN !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_fill_start got mreq=%0b addr=%h wren=%0b want 1 00000080 0",
               bus.oMEM_REQ, bus.oMEM_ADDR, bus.oRAM_WREN);
    end
    bus.iMEM_ACK = 1'b1;
    tick();
    bus.iMEM_ACK = 1'b0;
    bus.iSTORE_REQ = 1'b1;
    #1;
    n_vec++;
    if (bus.oSTORE_ACK !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_store_in_fill got ack=%0b want 0", bus.oSTORE_ACK);
    end
    tick();
    bus.iSTORE_REQ = 1'b0;
    send_beats(d, 8, 0);
    n_vec++;
    if (bus.oRAM_WREN !== 1'b1 || bus.oRAM_WRADDRESS !== 4'd4 ||
        bus.oRAM_DATA !== {32'hF000_0007, 32'hF000_0006, 32'hF000_0005, 32'hF000_0004,
                           32'hF000_0003, 32'hF000_0002, 32'hF000_0001, 32'hF000_0000}) begin
      n_err++;
      $display("FAIL b2b_fill_write got wren=%0b entry=%0d data=%h want 1 4 f0000007..f0000000",
               bus.oRAM_WREN, bus.oRAM_WRADDRESS, bus.oRAM_DATA);
    end
    tick();
    bus.iFILL_REQ = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_fill();
    logic [7:0][31:0] d;
    int w0;
    for (int k = 0; k < 8; k++) d[k] = 32'h5000_0000 | 32'(k);
    bus.iFILL_ADDR = 32'h2000_01A0; bus.iFILL_REQ = 1'b1;
    tick();
    bus.iMEM_ACK = 1'b1;
    tick();
    bus.iMEM_ACK = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.iMEM_VALID = 1'b1; bus.iMEM_DATA = 32'hDEAD_0000 | 32'(k);
      tick();
    end
    bus.iMEM_VALID = 1'b0;
    inRESET = 1'b0;
    bus.iFILL_REQ = 1'b0;
    #1;
    n_vec++;
    if (bus.oFILL_BUSY !== 1'b0 || bus.oRAM_DATA !== 256'h0 || bus.oRAM_BYTEENA !== 32'h0 ||
        bus.oRAM_WREN !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_outputs got busy=%0b wren=%0b be=%h want 0 0 00000000",
               bus.oFILL_BUSY, bus.oRAM_WREN, bus.oRAM_BYTEENA);
    end
    tick();
    inRESET = 1'b1;
    w0 = wr_cnt;
    for (int k = 0; k < 4; k++) begin
      bus.iMEM_VALID = 1'b1; bus.iMEM_DATA = 32'hBAD0_0000 | 32'(k);
      tick();
    end
    bus.iMEM_VALID = 1'b0;
    n_vec++;
    if (bus.oFILL_BUSY !== 1'b0 || wr_cnt != w0) begin
      n_err++;
      $display("FAIL rst_stray_beats got busy=%0b writes=%0d want 0 %0d", bus.oFILL_BUSY, wr_cnt, w0);
    end
    bus.iFILL_ADDR = 32'h0000_00E0; bus.iFILL_REQ = 1'b1;
    tick();
    bus.iMEM_ACK = 1'b1;
    tick();
    bus.iMEM_ACK = 1'b0;
    send_beats(d, 8, 0);
    n_vec++;
    if (bus.oRAM_WREN !== 1'b1 || bus.oRAM_WRADDRESS !== 4'd7 ||
        bus.oRAM_DATA !== {32'h5000_0007, 32'h5000_0006, 32'h5000_0005, 32'h5000_0004,
                           32'h5000_0003, 32'h5000_0002, 32'h5000_0001, 32'h5000_0000}) begin
      n_err++;
      $display("FAIL rst_new_line got wren=%0b entry=%0d data=%h want 1 7 50000007..50000000",
               bus.oRAM_WREN, bus.oRAM_WRADDRESS, bus.oRAM_DATA);
    end
    tick();
    bus.iFILL_REQ = 1'b0;
    tick();
  endtask

  task automatic test_burst_order();
    logic [7:0][31:0] d;
    logic [31:0]  exp_addr;
    logic [255:0] exp;
    for (int k = 0; k < 8; k++) d[k] = 32'hC000_0000 | 32'(k);
`ifdef CACHE_FILL_CRITICAL_FIRST_EN
    exp_addr = 32'h0000_0014;
    exp = {32'hC000_0002, 32'hC000_0001, 32'hC000_0000, 32'hC000_0007,
           32'hC000_0006, 32'hC000_0005, 32'hC000_0004, 32'hC000_0003};
`else
    exp_addr = 32'h0000_0000;
    exp = {32'hC000_0007, 32'hC000_0006, 32'hC000_0005, 32'hC000_0004,
           32'hC000_0003, 32'hC000_0002, 32'hC000_0001, 32'hC000_0000};
`endif
    bus.iFILL_ADDR = 32'h0000_0014; bus.iFILL_REQ = 1'b1;
    tick();
    n_vec++;
    if (bus.oMEM_ADDR !== exp_addr) begin
      n_err++;
      $display("FAIL order_memaddr got %h want %h", bus.oMEM_ADDR, exp_addr);
    end
    bus.iMEM_ACK = 1'b1;
    tick();
    bus.iMEM_ACK = 1'b0;
    send_beats(d, 8, 0);
    n_vec++;
    if (bus.oRAM_WREN !== 1'b1 || bus.oRAM_WRADDRESS !== 4'd0 || bus.oRAM_DATA !== exp) begin
      n_err++;
      $display("FAIL order_line got wren=%0b entry=%0d data=%h want 1 0 %h",
               bus.oRAM_WREN, bus.oRAM_WRADDRESS, bus.oRAM_DATA, exp);
    end
    tick();
    bus.iFILL_REQ = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_store();
    test_back_to_back();
    test_reset_mid_fill();
    test_burst_order();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/cache_line_fill_ctrl.md
Name: cache_line_fill_ctrl

Overview:
- Write-side front end of the 16-entry x 256-bit instruction/data cache line RAM.
- On a miss, issues one 8-beat x 32-bit burst read to memory and assembles the beats into a 256-bit line.
- Writes the assembled line into the RAM with all 32 byte enables set.
- In idle, also converts 32-bit byte-masked store hits into single-cycle partial-line writes, driving wren/wraddress/data/byteena.

Parameters:
- LINE_BEATS, 8, beats per line; fixed by 256/32, not to be overridden.
- INDEX_LSB, 5, lowest address bit of the 4-bit entry index; entry = addr[INDEX_LSB+3:INDEX_LSB].

Ports:
- iCLOCK  in  1  clock; all state on rising edge
- inRESET  in  1  asynchronous active-low reset
- iFILL_REQ  in  1  line fill request; level, held by requester until oFILL_DONE
- iFILL_ADDR  in  32  miss byte address
- oFILL_BUSY  out  1  fill in progress (state != IDLE)
- oFILL_DONE  out  1  one-cycle pulse, line written
- oMEM_REQ  out  1  burst read request
- oMEM_ADDR  out  32  burst start address
- iMEM_ACK  in  1  request accepted
- iMEM_VALID  in  1  read beat valid
- iMEM_DATA  in  32  read beat data
- iSTORE_REQ  in  1  store-hit write request
- iSTORE_ENTRY  in  4  target entry
- iSTORE_WORD  in  3  word within line
- iSTORE_MASK  in  4  byte mask within word
- iSTORE_DATA  in  32  store data
- oSTORE_ACK  out  1  store accepted this cycle (combinational)
- oRAM_WREN  out  1  RAM write enable
- oRAM_WRADDRESS  out  4  RAM entry
- oRAM_BYTEENA  out  32  RAM byte enables
- oRAM_DATA  out  256  RAM write data

Behaviour:
- Reset (async, inRESET=0): state IDLE, beat counter 0, line buffer 0. All outputs 0. Reset mid-fill abandons the burst; later iMEM_VALID beats are ignored until a new REQ state.
- States and transitions:
  - IDLE: store checked first. If iSTORE_REQ=1, oSTORE_ACK=1 and a store write is registered for the next cycle; fill is not started this cycle (store wins simultaneous events). Else if iFILL_REQ=1, capture iFILL_ADDR and go to REQ.
  - REQ: oMEM_REQ=1, oMEM_ADDR={addr[31:5],5'b0}. Hold until iMEM_ACK=1, then go to FILL with beat=0. iMEM_VALID in REQ is ignored.
  - FILL: each iMEM_VALID=1 stores iMEM_DATA into line bits [32k+31:32k] (k = current word slot) and increments beat. Gaps between beats are allowed. The cycle beat 7 arrives, go to WRITE.
  - WRITE: one cycle. oRAM_WREN=1, oRAM_WRADDRESS=captured entry, oRAM_BYTEENA=32'hFFFFFFFF, oRAM_DATA=line. Go to DONE.
  - DONE: oFILL_DONE=1 for one cycle, then IDLE. A RAM read issued this cycle returns the new line (registered-read RAM).
- iFILL_REQ and iSTORE_REQ outside IDLE: oSTORE_ACK=0, requests not captured.
- Store write (cycle after ack):
  - oRAM_WREN=1, oRAM_WRADDRESS=entry.
  - oRAM_BYTEENA=zero-extend(mask) << (word*4).
  - oRAM_DATA = iSTORE_DATA replicated 8 times.
  - mask=0 still writes with zero byte enables (no data change).
- Back-to-back: a store may be acked in the cycle its predecessor's write is driven, giving one store per cycle. A fill request arriving then starts only in the first IDLE cycle with no store.
- oRAM_* are registered. oRAM_WREN is never high in REQ, FILL or DONE.

Optional Feature:
- CACHE_FILL_CRITICAL_FIRST_EN defined:
  - oMEM_ADDR={addr[31:2],2'b00}.
  - Memory returns a wrapping burst starting at the critical word w=addr[4:2]; beat k goes to slot (w+k) mod 8.
  - Completion is still after 8 beats.
- Undefined: burst is aligned, slot = k, addr[4:2] is ignored.

Test Plan:
- Reset then idle 10 cycles -> all outputs 0, no oRAM_WREN.
- Fill iFILL_ADDR=32'h0000_1260, ack after 3 cycles, beats 32'h0..32'h7 with a 2-cycle gap after beat 3 -> oMEM_ADDR=32'h0000_1260 (aligned form, low 5 bits already 0); one write to entry 3, byteena all ones, data {32'h7,...,32'h0}; oFILL_DONE next cycle.
- Store entry 5, word 6, mask 4'b0110, data 32'hAABBCCDD -> ack same cycle; next cycle byteena=32'h0600_0000, wraddress 5, data = 32'hAABBCCDD x8.
- iSTORE_REQ and iFILL_REQ together in IDLE -> store acked and written first; fill oMEM_REQ rises the cycle after the store write. iSTORE_REQ during FILL -> oSTORE_ACK stays 0.
- inRESET low after 4 beats, release, 4 stray beats, new fill -> stray beats ignored, new line is uncorrupted.
- With CACHE_FILL_CRITICAL_FIRST_EN and addr 32'h0000_0014 -> oMEM_ADDR=32'h14; beats 0..7 land in slots 5,6,7,0,1,2,3,4.
